// File: rtl/pe_col_ctrl_pkg.sv
// Shared types and helpers for the PE column controller.
package pe_col_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

  // One operand-buffer read cycle plus two register stages per PE.
  function automatic int unsigned pipe_lat(input int unsigned num_pe);
    return 1 + 2 * num_pe;
  endfunction

endpackage

// File: rtl/pe_col_ctrl_valid_delay_line.sv
// Fixed-depth valid delay line tracking operands through the PE column.
// DEPTH must be at least 2.
module valid_delay_line #(
  parameter int unsigned DEPTH = 17
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic valid_i,
  output logic valid_o
);

  logic [DEPTH-1:0] sr_q;

  // Shift one position per cycle; flush drops every in-flight valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else if (flush) begin
      sr_q <= '0;
    end else begin
      sr_q <= {sr_q[DEPTH-2:0], valid_i};
    end
  end

  assign valid_o = sr_q[DEPTH-1];

endmodule

// File: rtl/pe_col_ctrl.sv
// Sequencer for a column of chained PEs: feeds operand reads, tracks
// results through the pipeline and signals job completion.
// Optional busy-cycle counter enabled by defining PE_COL_CTRL_PERF_EN.
module pe_col_ctrl
  import pe_col_ctrl_pkg::*;
#(
  parameter int unsigned NUM_PE = 8,
  parameter int unsigned LEN_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             abort,
  output logic             busy,
  output logic             rd_en,
  output logic [LEN_W-1:0] rd_addr,
  output logic             head_psum_zero,
  output logic             res_valid,
  output logic [LEN_W-1:0] res_addr,
  output logic             done,
  output logic [31:0]      perf_cycles
);

  localparam int unsigned PIPE_LAT = pipe_lat(NUM_PE);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0] rcnt_q, rcnt_d;
  logic             dl_out;
  logic             kill;

  assign kill           = abort && (state_q != ST_IDLE);
  assign busy           = (state_q != ST_IDLE);
  assign rd_en          = (state_q == ST_FEED) && !abort;
  assign head_psum_zero = rd_en;
  assign res_valid      = dl_out && !abort;
  assign done           = (state_q == ST_FIN) && !abort;
  assign rd_addr        = addr_q;
  assign res_addr       = rcnt_q;

  valid_delay_line #(
    .DEPTH (PIPE_LAT)
  ) u_dl (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (kill),
    .valid_i (rd_en),
    .valid_o (dl_out)
  );

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      addr_q  <= '0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      rcnt_q  <= rcnt_d;
    end
  end

  // Next-state logic; DRAIN exits on the cycle the last result issues so
  // done lands one cycle after it. Abort overrides every other transition.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    addr_d  = addr_q;
    rcnt_d  = rcnt_q;
    if (res_valid) begin
      rcnt_d = rcnt_q + LEN_W'(1);
    end
    unique case (state_q)
      ST_IDLE: begin
        addr_d = '0;
        rcnt_d = '0;
        if (start) begin
          if (cfg_len != '0) begin
            len_d   = cfg_len;
            state_d = ST_FEED;
          end else begin
            state_d = ST_FIN;
          end
        end
      end
      ST_FEED: begin
        addr_d = addr_q + LEN_W'(1);
        if (addr_q == len_q - LEN_W'(1)) begin
          addr_d  = '0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (res_valid && (rcnt_q == len_q - LEN_W'(1))) begin
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (kill) begin
      state_d = ST_IDLE;
      addr_d  = '0;
      rcnt_d  = '0;
    end
  end

`ifdef PE_COL_CTRL_PERF_EN
  logic [31:0] cyc_q, perf_q;

  // Busy-cycle counter; the FIN cycle itself is included in the loaded value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q  <= '0;
      perf_q <= '0;
    end else if (kill) begin
      cyc_q <= '0;
    end else if (done) begin
      perf_q <= cyc_q + 32'd1;
      cyc_q  <= '0;
    end else if (busy) begin
      cyc_q <= cyc_q + 32'd1;
    end
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_pe_col_ctrl.sv
// Directed self-checking bench for pe_col_ctrl (NUM_PE=8, PIPE_LAT=17).
module tb_pe_col_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  cfg_len;
  logic        abort;
  logic        busy, rd_en, head_psum_zero, res_valid, done;
  logic [7:0]  rd_addr, res_addr;
  logic [31:0] perf_cycles;

  int passed = 0;
  int total  = 0;

  pe_col_ctrl #(
    .NUM_PE (8),
    .LEN_W  (8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .cfg_len        (cfg_len),
    .abort          (abort),
    .busy           (busy),
    .rd_en          (rd_en),
    .rd_addr        (rd_addr),
    .head_psum_zero (head_psum_zero),
    .res_valid      (res_valid),
    .res_addr       (res_addr),
    .done           (done),
    .perf_cycles    (perf_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_perf(input int len);
`ifdef PE_COL_CTRL_PERF_EN
    return (len == 0) ? 1 : len + 18;
`else
    return 0;
`endif
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_rd_en"}, 32'(rd_en), 0);
    chk({tag, "_raddr"}, 32'(rd_addr), 0);
    chk({tag, "_hpz"},   32'(head_psum_zero), 0);
    chk({tag, "_rv"},    32'(res_valid), 0);
    chk({tag, "_waddr"}, 32'(res_addr), 0);
    chk({tag, "_done"},  32'(done), 0);
    chk({tag, "_perf"},  perf_cycles, 0);
  endtask

  // Runs one job from IDLE; poke_cyc > 0 re-pulses start with another length
  // in that cycle, which must be ignored.
  task automatic run_job(input int len, input int poke_cyc);
    int done_c;
    bit rd_x, rv_x;
    done_c  = (len == 0) ? 1 : len + 18;
    start   = 1'b1;
    cfg_len = 8'(len);
    tick();
    start = 1'b0;
    for (int c = 1; c <= done_c + 1; c++) begin
      if (c == poke_cyc) begin
        start   = 1'b1;
        cfg_len = 8'd9;
      end else begin
        start = 1'b0;
      end
      rd_x = (len != 0) && (c <= len);
      rv_x = (len != 0) && (c >= 18) && (c <= len + 17);
      chk($sformatf("busy_c%0d", c),  32'(busy), 32'(c <= done_c));
      chk($sformatf("rd_en_c%0d", c), 32'(rd_en), 32'(rd_x));
      chk($sformatf("hpz_c%0d", c),   32'(head_psum_zero), 32'(rd_x));
      if (rd_x) chk($sformatf("rd_addr_c%0d", c), 32'(rd_addr), 32'(c - 1));
      chk($sformatf("res_valid_c%0d", c), 32'(res_valid), 32'(rv_x));
      if (rv_x) chk($sformatf("res_addr_c%0d", c), 32'(res_addr), 32'(c - 18));
      chk($sformatf("done_c%0d", c), 32'(done), 32'(c == done_c));
      tick();
    end
    start = 1'b0;
    chk($sformatf("perf_len%0d", len), perf_cycles, 32'(exp_perf(len)));
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    cfg_len = '0;
    abort   = 1'b0;
    #2;
    chk_all_zero("reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Basic job, zero-length job, long job with read/result overlap.
    run_job(4, 0);
    run_job(0, 0);
    run_job(30, 0);
    run_job(4, 0);

    // Abort on the third DRAIN cycle (cycles 5,6,7 are DRAIN for len 4).
    start   = 1'b1;
    cfg_len = 8'd4;
    tick();
    start = 1'b0;
    for (int c = 1; c < 7; c++) tick();
    abort = 1'b1;
    chk("abort_busy", 32'(busy), 1);
    chk("abort_rd_en", 32'(rd_en), 0);
    chk("abort_rv", 32'(res_valid), 0);
    chk("abort_done", 32'(done), 0);
    tick();
    abort = 1'b0;
    chk("abort_idle", 32'(busy), 0);
    for (int c = 8; c <= 26; c++) begin
      chk($sformatf("abort_rv_c%0d", c), 32'(res_valid), 0);
      chk($sformatf("abort_done_c%0d", c), 32'(done), 0);
      tick();
    end
    chk("abort_perf", perf_cycles, 32'(exp_perf(4)));

    // Start re-pulsed during FEED is ignored.
    run_job(4, 2);

    // Asynchronous reset mid-FEED, then a fresh job.
    start   = 1'b1;
    cfg_len = 8'd30;
    tick();
    start = 1'b0;
    for (int c = 1; c < 5; c++) tick();
    chk("pre_rst_rd_en", 32'(rd_en), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    tick();
    rst_n = 1'b1;
    tick();
    run_job(4, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
